// File: rtl/ctr_input_packer.sv
// ctr_input_packer
// Packs a valid/ready byte stream into the flat multi-block plaintext bus of the CTR engine.
// The final block is zero-padded. On end-of-message the block runs one start pulse, holds the
// bus until the engine reports done, then clears it and re-opens for the next message.
// A message longer than the bus capacity is truncated. The excess bytes are drained and
// discarded up to s_last.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_last byte stream in; s_ready out (byte taken when s_valid & s_ready)
//   plaintext             packed message, byte k of block j at [j*BLOCK_SIZE + 8*k +: 8]
//   num_blocks, pad_bytes block count and zero-fill bytes of the last block
//   ctr_start, ctr_done   one-cycle start pulse to the engine / engine completion
//   busy                  high whenever not collecting a message
//   overflow              one-cycle pulse when a message exceeds bus capacity
module ctr_input_packer #(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned MAX_BLOCKS = 16,
    localparam int unsigned BPB = BLOCK_SIZE / 8,
    localparam int unsigned BW  = $clog2(BPB),
    localparam int unsigned KW  = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       s_data,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [BLOCK_SIZE*MAX_BLOCKS-1:0] plaintext,
    output logic [15:0]                      num_blocks,
    output logic [BW-1:0]                    pad_bytes,
    output logic                             ctr_start,
    input  logic                             ctr_done,
    output logic                             busy,
    output logic                             overflow
);

    typedef enum logic [1:0] {StCollect, StLaunch, StWaitDone, StDrain} state_e;

    state_e                              state_q;
    logic [MAX_BLOCKS-1:0][BPB-1:0][7:0] bus_q;
    logic [BW-1:0]                       byte_idx_q;
    logic [15:0]                         blk_idx_q;
    logic                                trunc_q;
    logic [15:0]                         num_blocks_q;
    logic [BW-1:0]                       pad_q;
    logic                                start_q;
    logic                                ovf_q;

    logic accept;
    logic byte_wrap;
    logic last_slot;

    assign s_ready   = (state_q == StCollect) || (state_q == StDrain);
    assign busy      = (state_q != StCollect);
    assign accept    = s_valid && s_ready;
    assign byte_wrap = (byte_idx_q == BW'(BPB - 1));
    // Final byte position of the bus: the message ends here whether or not s_last is set.
    assign last_slot = byte_wrap && (blk_idx_q == 16'(MAX_BLOCKS - 1));

    assign plaintext  = bus_q;
    assign num_blocks = num_blocks_q;
    assign pad_bytes  = pad_q;
    assign ctr_start  = start_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StCollect;
            bus_q        <= '0;
            byte_idx_q   <= '0;
            blk_idx_q    <= '0;
            trunc_q      <= 1'b0;
            num_blocks_q <= '0;
            pad_q        <= '0;
            start_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    if (accept) begin
                        bus_q[blk_idx_q[KW-1:0]][byte_idx_q] <= s_data;
                        if (s_last) begin
                            num_blocks_q <= blk_idx_q + 16'd1;
                            // Equals (BPB - (byte_idx + 1)) % BPB for byte_idx in 0..BPB-1.
                            pad_q        <= BW'(BPB - 1) - byte_idx_q;
                            start_q      <= 1'b1;
                            state_q      <= StLaunch;
                        end else if (last_slot) begin
                            num_blocks_q <= 16'(MAX_BLOCKS);
                            pad_q        <= '0;
                            ovf_q        <= 1'b1;
                            trunc_q      <= 1'b1;
                            start_q      <= 1'b1;
                            state_q      <= StLaunch;
                        end else if (byte_wrap) begin
                            byte_idx_q <= '0;
                            blk_idx_q  <= blk_idx_q + 16'd1;
                        end else begin
                            byte_idx_q <= byte_idx_q + BW'(1);
                        end
                    end
                end
                StLaunch: begin
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    // The engine reads the bus combinationally, so it only changes after done.
                    if (ctr_done) begin
                        bus_q      <= '0;
                        byte_idx_q <= '0;
                        blk_idx_q  <= '0;
                        state_q    <= trunc_q ? StDrain : StCollect;
                    end
                end
                StDrain: begin
                    if (accept && s_last) begin
                        trunc_q <= 1'b0;
                        state_q <= StCollect;
                    end
                end
                default: begin
                    state_q <= StCollect;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_input_packer.sv
module tb_ctr_input_packer;

    localparam int BS  = 64;
    localparam int MB  = 16;
    localparam int BPB = BS / 8;
    localparam int CAP = BPB * MB;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [BS*MB-1:0] plaintext;
    logic [15:0]     num_blocks;
    logic [2:0]      pad_bytes;
    logic            ctr_start;
    logic            ctr_done;
    logic            busy;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    ctr_input_packer #(
        .BLOCK_SIZE(BS),
        .MAX_BLOCKS(MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .plaintext (plaintext),
        .num_blocks(num_blocks),
        .pad_bytes (pad_bytes),
        .ctr_start (ctr_start),
        .ctr_done  (ctr_done),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  len;
        byte base;
        int  nb;
        int  pad;
        bit  ovf;
    } vec_t;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [BS*MB-1:0] exp);
        bit shown;
        shown = 1'b0;
        checks++;
        if (plaintext !== exp) begin
            failures++;
            for (int j = 0; j < MB; j++) begin
                if (!shown && plaintext[j*BS +: BS] !== exp[j*BS +: BS]) begin
                    $display("FAIL %s block%0d actual=%h expected=%h", nm, j,
                             plaintext[j*BS +: BS], exp[j*BS +: BS]);
                    shown = 1'b1;
                end
            end
        end
    endtask

    // Reference: byte i of the message lands at bit 8*i of the bus; bytes past capacity are lost.
    function automatic logic [BS*MB-1:0] build_bus(input byte msg[$]);
        logic [BS*MB-1:0] b;
        b = '0;
        for (int i = 0; i < msg.size() && i < CAP; i++) b[i*8 +: 8] = msg[i];
        return b;
    endfunction

    // Streams the captured part of a message, then checks the launch cycle.
    task automatic collect(input byte msg[$], input int gap, input bit spur,
                           input int enb, input int epad, input bit eovf);
        int n;
        int eff;
        int i;
        int guard;
        n     = msg.size();
        eff   = (n > CAP) ? CAP : n;
        i     = 0;
        guard = 0;
        while (i < eff && guard < 5000) begin
            chk("collect_ready", s_ready, 1);
            chk("collect_busy", busy, 0);
            ctr_done = spur && ($urandom_range(1) == 1);
            if ($urandom_range(99) < gap) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = msg[i];
                s_last  = (i == n - 1);
                i++;
            end
            tick();
            guard++;
        end
        chk("collect_timeout", i, eff);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ctr_done = 1'b0;
        chk("launch_start", ctr_start, 1);
        chk("launch_ready", s_ready, 0);
        chk("launch_busy", busy, 1);
        chk("launch_ovf", overflow, eovf);
        chk("launch_nb", num_blocks, enb);
        chk("launch_pad", pad_bytes, epad);
        chk_bus("launch_bus", build_bus(msg));
    endtask

    // Fake engine: holds off done for dly cycles, then drains any truncated tail.
    task automatic complete_msg(input byte msg[$], input int dly,
                                input int enb, input int epad, input bit eovf);
        logic [BS*MB-1:0] exp;
        int n;
        int i;
        int guard;
        exp = build_bus(msg);
        n   = msg.size();
        tick();
        for (int c = 0; c < dly; c++) begin
            chk("wait_start", ctr_start, 0);
            chk("wait_ready", s_ready, 0);
            chk("wait_busy", busy, 1);
            chk("wait_ovf", overflow, 0);
            chk("wait_nb", num_blocks, enb);
            chk_bus("wait_bus", exp);
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            tick();
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ctr_done = 1'b1;
        tick();
        ctr_done = 1'b0;
        chk_bus("done_clear", '0);
        chk("done_busy", busy, eovf);
        chk("done_ready", s_ready, 1);
        chk("done_nb_held", num_blocks, enb);
        chk("done_pad_held", pad_bytes, epad);
        if (eovf) begin
            i     = CAP;
            guard = 0;
            while (i < n && guard < 5000) begin
                chk("drain_ready", s_ready, 1);
                chk("drain_busy", busy, 1);
                if ($urandom_range(99) < 30) begin
                    s_valid = 1'b0;
                    s_last  = 1'($urandom);
                end else begin
                    s_valid = 1'b1;
                    s_data  = 8'($urandom);
                    s_last  = (i == n - 1);
                    i++;
                end
                tick();
                guard++;
            end
            chk("drain_timeout", i, n);
            s_valid = 1'b0;
            s_last  = 1'b0;
            chk("drain_exit_busy", busy, 0);
            chk_bus("drain_bus_zero", '0);
        end
    endtask

    task automatic run_msg(input byte msg[$], input int gap, input bit spur, input int dly,
                           input int enb, input int epad, input bit eovf);
        collect(msg, gap, spur, enb, epad, eovf);
        complete_msg(msg, dly, enb, epad, eovf);
    endtask

    task automatic make_seq(input int len, input byte base, output byte msg[$]);
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(byte'(base + i));
    endtask

    initial begin
        vec_t tbl[10];
        byte  msg[$];
        int   n;
        int   eff;
        int   nb;

        tbl[0] = '{len: 1,   base: 8'hA0, nb: 1,  pad: 7, ovf: 1'b0};
        tbl[1] = '{len: 3,   base: 8'h30, nb: 1,  pad: 5, ovf: 1'b0};
        tbl[2] = '{len: 8,   base: 8'h00, nb: 1,  pad: 0, ovf: 1'b0};
        tbl[3] = '{len: 9,   base: 8'h40, nb: 2,  pad: 7, ovf: 1'b0};
        tbl[4] = '{len: 11,  base: 8'h10, nb: 2,  pad: 5, ovf: 1'b0};
        tbl[5] = '{len: 16,  base: 8'h50, nb: 2,  pad: 0, ovf: 1'b0};
        tbl[6] = '{len: 127, base: 8'h01, nb: 16, pad: 1, ovf: 1'b0};
        tbl[7] = '{len: 128, base: 8'h80, nb: 16, pad: 0, ovf: 1'b0};
        tbl[8] = '{len: 129, base: 8'h11, nb: 16, pad: 0, ovf: 1'b1};
        tbl[9] = '{len: 130, base: 8'h22, nb: 16, pad: 0, ovf: 1'b1};

        reset    = 1'b1;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ctr_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", ctr_start, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_nb", num_blocks, 0);
        chk("rst_pad", pad_bytes, 0);
        chk_bus("rst_bus", '0);

        // Single full block.
        make_seq(8, 8'h00, msg);
        collect(msg, 0, 1'b0, 1, 0, 1'b0);
        chk("t1_block0", plaintext[63:0], 64'h0706050403020100);
        complete_msg(msg, 2, 1, 0, 1'b0);

        // Partial second block.
        make_seq(11, 8'h10, msg);
        collect(msg, 0, 1'b0, 2, 5, 1'b0);
        chk("t2_block1", plaintext[127:64], 64'h00000000001A1918);
        complete_msg(msg, 2, 2, 5, 1'b0);

        // Long engine job, then a short message must see no stale bytes.
        make_seq(8, 8'hC0, msg);
        run_msg(msg, 0, 1'b0, 40, 1, 0, 1'b0);
        make_seq(3, 8'hE0, msg);
        collect(msg, 0, 1'b0, 1, 5, 1'b0);
        chk("t3_upper_zero", plaintext[63:24], 40'h0);
        chk("t3_low", plaintext[23:0], 24'hE2E1E0);
        complete_msg(msg, 1, 1, 5, 1'b0);

        for (int v = 0; v < 10; v++) begin
            make_seq(tbl[v].len, tbl[v].base, msg);
            run_msg(msg, 0, 1'b0, 3, tbl[v].nb, tbl[v].pad, tbl[v].ovf);
        end

        // Reset while waiting on the engine aborts the job.
        make_seq(5, 8'h70, msg);
        collect(msg, 0, 1'b0, 1, 3, 1'b0);
        tick();
        tick();
        chk("t5_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_bus("t5_bus", '0);
        chk("t5_start", ctr_start, 0);
        chk("t5_ready", s_ready, 1);
        chk("t5_busy", busy, 0);

        // Gapped stream with spurious done while collecting.
        make_seq(20, 8'h90, msg);
        run_msg(msg, 50, 1'b1, 4, 3, 4, 1'b0);

        // Random messages against the arithmetic reference.
        for (int r = 0; r < 15; r++) begin
            n   = $urandom_range(140, 1);
            msg = {};
            for (int i = 0; i < n; i++) msg.push_back(byte'($urandom));
            eff = (n > CAP) ? CAP : n;
            nb  = (eff + BPB - 1) / BPB;
            run_msg(msg, 30, 1'b1, $urandom_range(10, 0), nb, nb * BPB - eff, n > CAP);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
